lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store control stage between the MEM-stage pipeline register and the byte-addressed data memory. It accepts one access per cycle through a valid/ready handshake and drives the memory port (`write_en`, `type_control`, `addr`, `din`, `sign_ext`). It captures the memory's registered read data and returns it through a back-pressurable response channel, buffering it when the consumer stalls. It also range- and alignment-checks every access, suppresses faulting accesses, and records fault information.

## Interface

- `MEM_SIZE`, default `32'h20000`: memory size in bytes. Legal bytes are `0 .. MEM_SIZE-1`.
- `ALIGN_CHECK`, default `0`: when 1, a misaligned half or word access is a fault.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when `req_valid` is also high.
- `req_write` in 1: 1 = store, 0 = load.
- `req_type` in 2: access width, `00` byte, `01` half, `10` word, `11` illegal.
- `req_sign_ext` in 1: sign-extend load data.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, low bytes used.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out 32: load data; 0 on fault.
- `rsp_fault` out 1: the response belongs to a faulting access.
- `mem_we` out 1: to memory `write_en`.
- `mem_type` out 2: to memory `type_control`.
- `mem_addr` out 32: to memory `addr`.
- `mem_din` out 32: to memory `din`.
- `mem_sign_ext` out 1: to memory `sign_ext`.
- `mem_dout` in 32: from memory `dout`, registered one cycle after `mem_addr`/`mem_type`.
- `fault_addr` out 32: address of the most recent faulting access.
- `fault_cause` out 2: cause of the most recent fault; `00` none, `01` range, `10` misaligned, `11` illegal type.
- `fault_count` out 8: number of faults, saturating at 255.

## Operation

- Accept: `acc = req_valid & req_ready`.
- Fault evaluation for an accepted request, combinational, first match wins:
  - illegal type (`req_type == 11`);
  - range: `{1'b0,req_addr} + nbytes > MEM_SIZE`, computed in 33 bits so no wrap, with `nbytes` = 1, 2 or 4;
  - misaligned (only when `ALIGN_CHECK`): half with `addr[0]`, word with `addr[1:0] != 0`.
- Memory drive while accepting a non-faulting request:
  - `mem_addr = req_addr`, `mem_type = req_type`, `mem_sign_ext = req_sign_ext`, `mem_din = req_wdata`;
  - `mem_we = req_write`.
- Memory drive otherwise: `mem_we = 0`, `mem_addr = 0`, `mem_type = 10`. Faulting accesses never write and never present an out-of-range address.
- Response production:
  - Non-faulting load: one response, data = `mem_dout`.
  - Any faulting access (load or store): one response with `rsp_fault = 1`, `rsp_rdata = 0`.
  - Non-faulting store: no response; it completes at the accept edge.
- Response-path registers: `pend_q` (response source is the memory this cycle), `flt_q`, and `hold_q`/`hold_flt_q` (buffered response).
- FSM states:
  - IDLE: no response outstanding. `req_ready = 1`.
    - Accepting a load or a faulting access goes to RESP.
    - Otherwise stay in IDLE.
  - RESP: `rsp_valid = 1`. Data is `mem_dout` (or 0 if `flt_q`). `req_ready = rsp_ready`.
    - If `rsp_ready` and a new response-producing access is accepted, stay in RESP (back-to-back).
    - If `rsp_ready` and a non-faulting store or no request is accepted, go to IDLE.
    - If `!rsp_ready`, load `hold_q <= flt_q ? 0 : mem_dout`, load `hold_flt_q <= flt_q`, and go to HOLD.
  - HOLD: `rsp_valid = 1`, data from `hold_q`, `req_ready = 0`.
    - On `rsp_ready`, go to IDLE.
- Fault recording, on the accept edge of a faulting access:
  - `fault_addr <= req_addr`, `fault_cause <= cause`;
  - `fault_count` increments and saturates at 255.

## Timing

- Reset values:
  - state IDLE, `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_fault = 0`;
  - `mem_we = 0`, `mem_addr = 0`, `mem_type = 10`, `mem_din = 0`, `mem_sign_ext = 0`;
  - `fault_addr = 0`, `fault_cause = 00`, `fault_count = 0`, `hold_q = 0`.
- Store: memory written at the accept edge; zero added latency.
- Load: accepted in cycle N; `rsp_valid` high in cycle N+1. Sustained throughput is one load per cycle when `rsp_ready` stays high.
- Store in N followed by a load of the same address in N+1 returns the new data.
- `mem_dout` is valid only in the cycle after the address was presented, because the memory re-reads every edge. HOLD therefore exists, and nothing reads `mem_dout` outside RESP.
- `rsp_valid` and data stay stable until `rsp_ready`; there are no combinational paths from `rsp_ready` to `rsp_*`.
- Reset asserted mid-operation: any outstanding response is dropped and no write is issued.

## Test plan

- Store word `0xDEADBEEF` at `0x100`, then load byte signed at `0x103` -> `rsp_valid` in the next cycle, `rsp_rdata = 0xFFFFFFDE`; load half unsigned at `0x100` -> `0x0000BEEF`.
- Back-to-back loads of words at `0x10000`, `0x10004`, `0x10008` with `rsp_ready = 1` -> three consecutive responses matching the hex file, `req_ready` never low.
- Load at `0x200` with `rsp_ready = 0` for 3 cycles -> state HOLD, `req_ready = 0`, data stable; release -> a single response, then `req_ready = 1`.
- Word store at `0x1FFFE` (`MEM_SIZE` default) -> `mem_we` stays 0, response with `rsp_fault = 1`, `rsp_rdata = 0`, `fault_addr = 0x1FFFE`, `fault_cause = 01`, `fault_count = 1`.
- `ALIGN_CHECK = 1`, half load at `0x101` -> fault, cause `10`; `req_type = 11` -> cause `11`; 300 faults -> `fault_count = 255`.
- Assert `rst_n` low while in HOLD -> all outputs at reset values immediately; after release the next load responds normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl
//   Load/store control stage between the MEM-stage pipeline register and a
//   byte-addressed data memory with registered read data.
//   - Request channel (req_*): valid/ready handshake. Stores complete at the
//     accept edge. Loads and faulting accesses produce one response each.
//   - Response channel (rsp_*): back-pressurable. The response is buffered in
//     hold_q when the consumer stalls, because the memory re-reads on every edge.
//   - Memory port (mem_*): driven combinationally from an accepted request that
//     does not fault. Otherwise the port is parked at address 0, word type,
//     with no write.
//   - Fault status (fault_*): address and cause of the most recent fault, and a
//     saturating fault counter.
module lsu_ctrl #(
   parameter logic [31:0] MEM_SIZE    = 32'h20000,
   parameter bit          ALIGN_CHECK = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_type,
   input  logic        req_sign_ext,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        mem_we,
   output logic [1:0]  mem_type,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_sign_ext,
   input  logic [31:0] mem_dout,
   output logic [31:0] fault_addr,
   output logic [1:0]  fault_cause,
   output logic [7:0]  fault_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RESP = 2'b01,
      ST_HOLD = 2'b10
   } state_t;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_RANGE = 2'b01;
   localparam logic [1:0] CAUSE_ALIGN = 2'b10;
   localparam logic [1:0] CAUSE_TYPE  = 2'b11;

   // Fault cause for one access; the first matching check wins.
   // The range check works in 33 bits so that addresses near 2^32 cannot wrap.
   function automatic logic [1:0] fault_cause_f(input logic [1:0] typ, input logic [31:0] addr);
      logic [2:0]  nbytes;
      logic [32:0] end_addr;
      logic [1:0]  cause;
      case (typ)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
      end_addr = {1'b0, addr} + {30'd0, nbytes};
      if (typ == 2'b11) begin
         cause = CAUSE_TYPE;
      end else if (end_addr > {1'b0, MEM_SIZE}) begin
         cause = CAUSE_RANGE;
      end else if (ALIGN_CHECK && (((typ == 2'b01) && addr[0]) ||
                                   ((typ == 2'b10) && (addr[1:0] != 2'b00)))) begin
         cause = CAUSE_ALIGN;
      end else begin
         cause = CAUSE_NONE;
      end
      return cause;
   endfunction

   state_t      state_r, state_next_s;
   logic        pend_q, flt_q, hold_flt_q;
   logic [31:0] hold_q;
   logic [31:0] fault_addr_r;
   logic [1:0]  fault_cause_r;
   logic [7:0]  fault_count_r;

   logic [1:0]  cause_s;
   logic        fault_s;
   logic        acc_s;
   logic        rsp_prod_s;
   logic        req_ready_s;
   logic        hold_load_s;

   assign cause_s    = fault_cause_f(req_type, req_addr);
   assign fault_s    = (cause_s != CAUSE_NONE);
   // rst_n is included so that a request presented during reset is never accepted
   // and never reaches the memory write port.
   assign acc_s      = req_valid & req_ready_s & rst_n;
   assign rsp_prod_s = fault_s | ~req_write;

   // Ready and response outputs, decoded from the state register.
   always_comb begin
      req_ready_s = 1'b0;
      rsp_valid   = 1'b0;
      rsp_rdata   = 32'h0000_0000;
      rsp_fault   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            req_ready_s = 1'b1;
         end
         ST_RESP: begin
            req_ready_s = rsp_ready;
            rsp_valid   = 1'b1;
            rsp_rdata   = pend_q ? mem_dout : 32'h0000_0000;
            rsp_fault   = flt_q;
         end
         ST_HOLD: begin
            rsp_valid = 1'b1;
            rsp_rdata = hold_q;
            rsp_fault = hold_flt_q;
         end
         default: begin
            req_ready_s = 1'b0;
         end
      endcase
   end

   assign req_ready = req_ready_s;

   // Next-state logic. Also decides when the response is captured into the hold buffer.
   always_comb begin
      state_next_s = state_r;
      hold_load_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (acc_s && rsp_prod_s) begin
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RESP: begin
            if (!rsp_ready) begin
               hold_load_s  = 1'b1;
               state_next_s = ST_HOLD;
            end else if (acc_s && rsp_prod_s) begin
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (rsp_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Memory port drive. Faulting accesses leave the port parked.
   always_comb begin
      mem_we       = 1'b0;
      mem_type     = 2'b10;
      mem_addr     = 32'h0000_0000;
      mem_din      = 32'h0000_0000;
      mem_sign_ext = 1'b0;
      if (acc_s && !fault_s) begin
         mem_we       = req_write;
         mem_type     = req_type;
         mem_addr     = req_addr;
         mem_din      = req_wdata;
         mem_sign_ext = req_sign_ext;
      end else begin
         mem_we = 1'b0;
      end
   end

   // State register and response-path registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         pend_q     <= 1'b0;
         flt_q      <= 1'b0;
         hold_q     <= 32'h0000_0000;
         hold_flt_q <= 1'b0;
      end else begin
         state_r <= state_next_s;
         pend_q  <= acc_s & ~fault_s & ~req_write;
         flt_q   <= acc_s & fault_s;
         if (hold_load_s) begin
            // mem_dout is valid only this cycle, so capture it now.
            hold_q     <= flt_q ? 32'h0000_0000 : mem_dout;
            hold_flt_q <= flt_q;
         end
      end
   end

   // Fault recording on the accept edge of a faulting access; the counter saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_addr_r  <= 32'h0000_0000;
         fault_cause_r <= CAUSE_NONE;
         fault_count_r <= 8'd0;
      end else if (acc_s && fault_s) begin
         fault_addr_r  <= req_addr;
         fault_cause_r <= cause_s;
         if (fault_count_r != 8'hFF) begin
            fault_count_r <= fault_count_r + 8'd1;
         end
      end
   end

   assign fault_addr  = fault_addr_r;
   assign fault_cause = fault_cause_r;
   assign fault_count = fault_count_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl. u0 uses default parameters and is attached
// to a behavioural memory with registered read data; u1 has ALIGN_CHECK = 1
// and exercises only the fault paths.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        v0, v1;
   logic        r_write;
   logic [1:0]  r_type;
   logic        r_sext;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        rr;

   logic        u0_req_ready, u0_rsp_valid, u0_rsp_fault;
   logic [31:0] u0_rsp_rdata;
   logic        u0_mem_we, u0_mem_sext;
   logic [1:0]  u0_mem_type;
   logic [31:0] u0_mem_addr, u0_mem_din;
   logic [31:0] u0_mem_dout;
   logic [31:0] u0_fault_addr;
   logic [1:0]  u0_fault_cause;
   logic [7:0]  u0_fault_count;

   logic        u1_req_ready, u1_rsp_valid, u1_rsp_fault;
   logic [31:0] u1_rsp_rdata;
   logic        u1_mem_we, u1_mem_sext;
   logic [1:0]  u1_mem_type;
   logic [31:0] u1_mem_addr, u1_mem_din;
   logic [31:0] u1_mem_dout;
   logic [31:0] u1_fault_addr;
   logic [1:0]  u1_fault_cause;
   logic [7:0]  u1_fault_count;

   int tests_run;
   int tests_failed;

   logic [7:0] mem_b [0:32'h1FFFF];

   lsu_ctrl u0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v0), .req_ready(u0_req_ready), .req_write(r_write),
      .req_type(r_type), .req_sign_ext(r_sext), .req_addr(r_addr), .req_wdata(r_wdata),
      .rsp_valid(u0_rsp_valid), .rsp_ready(rr), .rsp_rdata(u0_rsp_rdata), .rsp_fault(u0_rsp_fault),
      .mem_we(u0_mem_we), .mem_type(u0_mem_type), .mem_addr(u0_mem_addr), .mem_din(u0_mem_din),
      .mem_sign_ext(u0_mem_sext), .mem_dout(u0_mem_dout),
      .fault_addr(u0_fault_addr), .fault_cause(u0_fault_cause), .fault_count(u0_fault_count)
   );

   lsu_ctrl #(.MEM_SIZE(32'h20000), .ALIGN_CHECK(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v1), .req_ready(u1_req_ready), .req_write(r_write),
      .req_type(r_type), .req_sign_ext(r_sext), .req_addr(r_addr), .req_wdata(r_wdata),
      .rsp_valid(u1_rsp_valid), .rsp_ready(rr), .rsp_rdata(u1_rsp_rdata), .rsp_fault(u1_rsp_fault),
      .mem_we(u1_mem_we), .mem_type(u1_mem_type), .mem_addr(u1_mem_addr), .mem_din(u1_mem_din),
      .mem_sign_ext(u1_mem_sext), .mem_dout(u1_mem_dout),
      .fault_addr(u1_fault_addr), .fault_cause(u1_fault_cause), .fault_count(u1_fault_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory read with byte/half/word width and optional sign extension.
   function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] t, input logic s);
      logic [16:0] i;
      logic [31:0] d;
      i = a[16:0];
      case (t)
         2'b00:   d = s ? {{24{mem_b[i][7]}}, mem_b[i]} : {24'd0, mem_b[i]};
         2'b01:   d = s ? {{16{mem_b[i+17'd1][7]}}, mem_b[i+17'd1], mem_b[i]}
                        : {16'd0, mem_b[i+17'd1], mem_b[i]};
         default: d = {mem_b[i+17'd3], mem_b[i+17'd2], mem_b[i+17'd1], mem_b[i]};
      endcase
      return d;
   endfunction

   // Memory model: writes at the edge, read data registered one cycle after the address.
   always @(posedge clk) begin
      if (u0_mem_we) begin
         mem_b[u0_mem_addr[16:0]] <= u0_mem_din[7:0];
         if (u0_mem_type != 2'b00) mem_b[u0_mem_addr[16:0] + 17'd1] <= u0_mem_din[15:8];
         if (u0_mem_type == 2'b10) begin
            mem_b[u0_mem_addr[16:0] + 17'd2] <= u0_mem_din[23:16];
            mem_b[u0_mem_addr[16:0] + 17'd3] <= u0_mem_din[31:24];
         end
      end
      u0_mem_dout <= mem_rd(u0_mem_addr, u0_mem_type, u0_mem_sext);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present a request at the falling edge.
   task automatic drive(input logic a0, input logic a1, input logic w, input logic [1:0] t,
                        input logic s, input logic [31:0] a, input logic [31:0] d, input logic r);
      @(negedge clk);
      v0 = a0; v1 = a1; r_write = w; r_type = t; r_sext = s;
      r_addr = a; r_wdata = d; rr = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_word(input logic [31:0] a, input logic [31:0] d);
      mem_b[a[16:0]]         = d[7:0];
      mem_b[a[16:0] + 17'd1] = d[15:8];
      mem_b[a[16:0] + 17'd2] = d[23:16];
      mem_b[a[16:0] + 17'd3] = d[31:24];
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      u1_mem_dout = 32'h0;
      for (int i = 0; i < 32'h20000; i++) mem_b[i] = 8'h00;
      put_word(32'h10000, 32'h11223344);
      put_word(32'h10004, 32'h55667788);
      put_word(32'h10008, 32'h99AABBCC);
      put_word(32'h00200, 32'hCAFEF00D);

      rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0; r_write = 1'b0; r_type = 2'b10; r_sext = 1'b0;
      r_addr = 32'h0; r_wdata = 32'h0; rr = 1'b1;
      #1;
      check_eq("rst_rsp_valid", {31'd0, u0_rsp_valid}, 32'd0);
      check_eq("rst_rsp_rdata", u0_rsp_rdata, 32'h0);
      check_eq("rst_mem_we", {31'd0, u0_mem_we}, 32'd0);
      check_eq("rst_mem_type", {30'd0, u0_mem_type}, 32'd2);
      check_eq("rst_fault_count", {24'd0, u0_fault_count}, 32'd0);
      check_eq("rst_fault_addr", u0_fault_addr, 32'h0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;

      // Store word, then loads of the same data.
      drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1);
      #1;
      check_eq("st_mem_we", {31'd0, u0_mem_we}, 32'd1);
      check_eq("st_mem_addr", u0_mem_addr, 32'h100);
      tick();
      check_eq("st_no_rsp", {31'd0, u0_rsp_valid}, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1);
      tick();
      check_eq("ldb_valid", {31'd0, u0_rsp_valid}, 32'd1);
      check_eq("ldb_data", u0_rsp_rdata, 32'hFFFFFFDE);
      drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 1'b1);
      tick();
      check_eq("ldh_data", u0_rsp_rdata, 32'h0000BEEF);
      drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 1'b1);
      tick();
      check_eq("ldh_misalign_ok", u0_rsp_rdata, 32'hFFFFADBE);
      check_eq("ldh_misalign_nf", {31'd0, u0_rsp_fault}, 32'd0);

      // Back-to-back word loads.
      drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, 1'b1);
      #1 check_eq("b2b_rdy0", {31'd0, u0_req_ready}, 32'd1);
      tick();
      check_eq("b2b_d0", u0_rsp_rdata, 32'h11223344);
      drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10004, 32'h0, 1'b1);
      #1 check_eq("b2b_rdy1", {31'd0, u0_req_ready}, 32'd1);
      tick();
      check_eq("b2b_d1", u0_rsp_rdata, 32'h55667788);
      drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10008, 32'h0, 1'b1);
      #1 check_eq("b2b_rdy2", {31'd0, u0_req_ready}, 32'd1);
      tick();
      check_eq("b2b_d2", u0_rsp_rdata, 32'h99AABBCC);
      check_eq("b2b_v2", {31'd0, u0_rsp_valid}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      check_eq("b2b_idle", {31'd0, u0_rsp_valid}, 32'd0);

      // Stalled consumer: response must be held.
      drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0);
      tick();
      check_eq("hold_resp_d", u0_rsp_rdata, 32'hCAFEF00D);
      drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      #1 check_eq("hold_resp_rdy", {31'd0, u0_req_ready}, 32'd0);
      tick();
      check_eq("hold_v", {31'd0, u0_rsp_valid}, 32'd1);
      check_eq("hold_d1", u0_rsp_rdata, 32'hCAFEF00D);
      check_eq("hold_rdy", {31'd0, u0_req_ready}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      check_eq("hold_d2", u0_rsp_rdata, 32'hCAFEF00D);
      drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      #1 check_eq("hold_rel_v", {31'd0, u0_rsp_valid}, 32'd1);
      tick();
      check_eq("hold_done_v", {31'd0, u0_rsp_valid}, 32'd0);
      check_eq("hold_done_rdy", {31'd0, u0_req_ready}, 32'd1);

      // Range fault on a word store straddling the end of memory.
      drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h1FFFE, 32'h12345678, 1'b1);
      #1;
      check_eq("rng_mem_we", {31'd0, u0_mem_we}, 32'd0);
      check_eq("rng_mem_addr", u0_mem_addr, 32'h0);
      tick();
      check_eq("rng_v", {31'd0, u0_rsp_valid}, 32'd1);
      check_eq("rng_flt", {31'd0, u0_rsp_fault}, 32'd1);
      check_eq("rng_data", u0_rsp_rdata, 32'h0);
      check_eq("rng_faddr", u0_fault_addr, 32'h1FFFE);
      check_eq("rng_cause", {30'd0, u0_fault_cause}, 32'd1);
      check_eq("rng_cnt", {24'd0, u0_fault_count}, 32'd1);
      // Last word of memory is legal.
      drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1FFFC, 32'h0, 1'b1);
      tick();
      check_eq("lastw_flt", {31'd0, u0_rsp_fault}, 32'd0);
      check_eq("lastw_cnt", {24'd0, u0_fault_count}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();

      // Alignment and illegal-type faults on the checking instance.
      drive(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h101, 32'h5555AAAA, 1'b1);
      #1;
      check_eq("al_mem_we", {31'd0, u1_mem_we}, 32'd0);
      check_eq("al_mem_addr", u1_mem_addr, 32'h0);
      check_eq("al_mem_type", {30'd0, u1_mem_type}, 32'd2);
      check_eq("al_mem_din", u1_mem_din, 32'h0);
      check_eq("al_mem_sext", {31'd0, u1_mem_sext}, 32'd0);
      tick();
      check_eq("al_flt", {31'd0, u1_rsp_fault}, 32'd1);
      check_eq("al_data", u1_rsp_rdata, 32'h0);
      check_eq("al_cause", {30'd0, u1_fault_cause}, 32'd2);
      check_eq("al_faddr", u1_fault_addr, 32'h101);
      drive(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b1);
      tick();
      check_eq("ty_cause", {30'd0, u1_fault_cause}, 32'd3);
      check_eq("ty_cnt", {24'd0, u1_fault_count}, 32'd2);
      drive(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 1'b1);
      tick();
      check_eq("alok_flt", {31'd0, u1_rsp_fault}, 32'd0);
      check_eq("alok_v", {31'd0, u1_rsp_valid}, 32'd1);
      for (int i = 0; i < 300; i++) begin
         drive(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'(i), 32'h0, 1'b1);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      check_eq("sat_cnt", {24'd0, u1_fault_count}, 32'd255);
      check_eq("sat_rdy", {31'd0, u1_req_ready}, 32'd1);

      // Reset while holding a response, with a store presented.
      drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      check_eq("prerst_v", {31'd0, u0_rsp_valid}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      v0 = 1'b1; r_write = 1'b1; r_type = 2'b10; r_addr = 32'h300; r_wdata = 32'h11111111;
      #1;
      check_eq("mrst_v", {31'd0, u0_rsp_valid}, 32'd0);
      check_eq("mrst_d", u0_rsp_rdata, 32'h0);
      check_eq("mrst_we", {31'd0, u0_mem_we}, 32'd0);
      check_eq("mrst_cnt", {24'd0, u0_fault_count}, 32'd0);
      tick();
      check_eq("mrst_nowrite", {24'd0, mem_b[32'h300]}, 32'd0);
      @(negedge clk);
      v0 = 1'b0;
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10004, 32'h0, 1'b1);
      tick();
      check_eq("postrst_v", {31'd0, u0_rsp_valid}, 32'd1);
      check_eq("postrst_d", u0_rsp_rdata, 32'h55667788);
      drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
